// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM/WB stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, stall, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, stall, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: RV32 byte/half/word loads and stores with sign/zero
// extension, alignment checking and a stall back to the pipeline while an access is in flight.
//
// state | meaning
// IDLE  | ready; a valid request is accepted on the next edge
// WAIT  | access in flight, counter runs until LATENCY-1
// RESP  | one-cycle completion, rsp_* valid, pipeline released
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;
  logic        accept;

  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic        cur_we;
  logic [1:0]  cur_size;
  logic        cur_unsigned;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] cur_idx;
  logic        cur_err;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  logic        unused_addr_bits;

  assign accept = (state == IDLE) && bus.req_valid;

  // With LATENCY=1 the RESP edge is also the acceptance edge, so the live request is used then.
  always_comb begin
    if (state == IDLE) begin
      cur_we       = bus.req_we;
      cur_size     = bus.req_size;
      cur_unsigned = bus.req_unsigned;
      cur_addr     = bus.req_addr;
      cur_wdata    = bus.req_wdata;
    end else begin
      cur_we       = cap_we;
      cur_size     = cap_size;
      cur_unsigned = cap_unsigned;
      cur_addr     = cap_addr;
      cur_wdata    = cap_wdata;
    end
  end

  assign cur_idx          = cur_addr[AW+1:2];
  assign unused_addr_bits = ^cur_addr[31:AW+2];

  always_comb begin
    cur_err = 1'b0;
    case (cur_size)
      2'b00:   cur_err = 1'b0;
      2'b01:   cur_err = cur_addr[0];
      2'b10:   cur_err = (cur_addr[1:0] != 2'b00);
      default: cur_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_nxt = 4'd1;
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we       <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'd0;
      cap_wdata    <= 32'd0;
    end else if (accept) begin
      cap_we       <= bus.req_we;
      cap_size     <= bus.req_size;
      cap_unsigned <= bus.req_unsigned;
      cap_addr     <= bus.req_addr;
      cap_wdata    <= bus.req_wdata;
    end
  end

  // Byte lanes replicate the low store data so every enabled lane sees the right bits.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = cur_wdata;
    case (cur_size)
      2'b00: begin
        wr_be    = 4'b0001 << cur_addr[1:0];
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        wr_be    = 4'b1111;
        wr_lanes = cur_wdata;
      end
      default: begin
        wr_be    = 4'b0000;
        wr_lanes = cur_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[cur_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = mem[cur_idx];
    rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
    ld_data  = rd_word;
    case (cur_size)
      2'b00:   ld_data = cur_unsigned ? {24'd0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = cur_unsigned ? {16'd0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  // Response registers load only on the RESP entry edge, so they clear by themselves on leaving RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'd0;
    end else begin
      bus.rsp_valid <= enter_resp;
      bus.rsp_err   <= enter_resp && cur_err;
      bus.rsp_rdata <= (enter_resp && !cur_err && !cur_we) ? ld_data : 32'd0;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.stall     = accept || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for sizing/errors/wrap/reset,
// LATENCY=1 instance for the back-to-back request stream.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (a_if)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on instance A; holds req_valid until the response pulse, then checks the result.
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int          stalls;
    int          lat;
    logic [31:0] rd;
    logic        er;
    stalls = 0;
    lat    = -1;
    rd     = 32'hxxxx_xxxx;
    er     = 1'bx;
    @(negedge clk);
    a_if.req_valid    = 1'b1;
    a_if.req_we       = we;
    a_if.req_size     = size;
    a_if.req_unsigned = uns;
    a_if.req_addr     = addr;
    a_if.req_wdata    = wdata;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (a_if.stall) stalls++;
      if (a_if.rsp_valid) begin
        lat = c;
        rd  = a_if.rsp_rdata;
        er  = a_if.rsp_err;
        break;
      end
      @(negedge clk);
    end
    a_if.req_valid = 1'b0;
    check({tag, ":lat"},   32'(lat),    32'd3);
    check({tag, ":stall"}, 32'(stalls), 32'd2);
    check({tag, ":rdata"}, rd,          exp_rdata);
    check({tag, ":err"},   {31'd0, er}, {31'd0, exp_err});
    @(negedge clk);
    #1;
    check({tag, ":post_valid"}, {31'd0, a_if.rsp_valid}, 32'd0);
    check({tag, ":post_rdata"}, a_if.rsp_rdata,          32'd0);
    check({tag, ":post_ready"}, {31'd0, a_if.req_ready}, 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_size = 2'b00;
    a_if.req_unsigned = 1'b0; a_if.req_addr = 32'd0; a_if.req_wdata = 32'd0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_size = 2'b00;
    b_if.req_unsigned = 1'b0; b_if.req_addr = 32'd0; b_if.req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    check("rst:ready", {31'd0, a_if.req_ready}, 32'd1);
    check("rst:stall", {31'd0, a_if.stall},     32'd0);
    check("rst:valid", {31'd0, a_if.rsp_valid}, 32'd0);
    check("rst:err",   {31'd0, a_if.rsp_err},   32'd0);
    check("rst:rdata", a_if.rsp_rdata,          32'd0);
    rst_n = 1'b1;

    // word store/load
    xact("st_w10", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0,         1'b0);
    xact("ld_w10", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0,         32'hDEAD_BEEF, 1'b0);

    // byte/half sizing and extension; word becomes 0x80ADBEEF
    xact("st_b13",  1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_1280, 32'd0,         1'b0);
    xact("ld_sb13", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0,         32'hFFFF_FF80, 1'b0);
    xact("ld_ub13", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'd0,         32'h0000_0080, 1'b0);
    xact("ld_sh12", 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0,         32'hFFFF_80AD, 1'b0);
    xact("ld_uh12", 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'd0,         32'h0000_80AD, 1'b0);
    xact("ld_sb11", 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'd0,         32'hFFFF_FFBE, 1'b0);
    xact("ld_sh10", 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'd0,         32'hFFFF_BEEF, 1'b0);
    xact("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0,         32'h80AD_BEEF, 1'b0);

    // alignment / reserved-size errors leave memory untouched
    xact("st_w100",  1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'd0,         1'b0);
    xact("ld_w102e", 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0,         32'd0,         1'b1);
    xact("st_h101e", 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_AAAA, 32'd0,         1'b1);
    xact("ld_rsv",   1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0,         32'd0,         1'b1);
    xact("ld_w100",  1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0,         32'h1122_3344, 1'b0);

    // address wrap modulo DEPTH words
    xact("st_w1000", 1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1234_5678, 32'd0,         1'b0);
    xact("ld_w0",    1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0,         32'h1234_5678, 1'b0);

    // half store into upper lanes
    xact("st_w20",  1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'd0,         1'b0);
    xact("st_h22",  1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h9999_BBCC, 32'd0,         1'b0);
    xact("ld_w20",  1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0,         32'hBBCC_F00D, 1'b0);

    // reset during WAIT of a store discards it
    @(negedge clk);
    a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_size = 2'b10;
    a_if.req_unsigned = 1'b0; a_if.req_addr = 32'h0000_0020; a_if.req_wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    check("rstmid:wait_stall", {31'd0, a_if.stall},     32'd1);
    check("rstmid:wait_ready", {31'd0, a_if.req_ready}, 32'd0);
    rst_n = 1'b0;
    a_if.req_valid = 1'b0;
    #1;
    check("rstmid:ready", {31'd0, a_if.req_ready}, 32'd1);
    check("rstmid:stall", {31'd0, a_if.stall},     32'd0);
    check("rstmid:valid", {31'd0, a_if.rsp_valid}, 32'd0);
    check("rstmid:rdata", a_if.rsp_rdata,          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xact("ld_w20_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0, 32'hBBCC_F00D, 1'b0);

    // LATENCY=1 stream with req_valid held high: store first, then continuous loads
    @(negedge clk);
    b_if.req_valid = 1'b1; b_if.req_we = 1'b1; b_if.req_size = 2'b10;
    b_if.req_unsigned = 1'b0; b_if.req_addr = 32'h0000_0000; b_if.req_wdata = 32'hA5A5_A5A5;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        #1;
        check($sformatf("b2b:valid%0d", k), {31'd0, b_if.rsp_valid}, {31'd0, k[0]});
        check($sformatf("b2b:ready%0d", k), {31'd0, b_if.req_ready}, {31'd0, ~k[0]});
        check($sformatf("b2b:stall%0d", k), {31'd0, b_if.stall},     {31'd0, ~k[0]});
        check($sformatf("b2b:rdata%0d", k), b_if.rsp_rdata,
              (k[0] && k > 1) ? 32'hA5A5_A5A5 : 32'd0);
        if (b_if.rsp_valid) pulses++;
        if (k == 1) b_if.req_we = 1'b0;
        @(negedge clk);
      end
      check("b2b:pulses", 32'(pulses), 32'd4);
    end
    b_if.req_valid = 1'b0;
    #1;
    check("b2b:tail_valid", {31'd0, b_if.rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("b2b:idle_valid", {31'd0, b_if.rsp_valid}, 32'd0);
    check("b2b:idle_ready", {31'd0, b_if.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
